scu_unit: RTL

Signal Control Unit (SCU): the actuation end of the patch path. It consumes trigger pulses from one or more `smu_unit` monitors and overrides selected bits of a controllable signal bus with programmed values. The override lasts a programmed number of cycles, or until software clears it. It sits between the SMU trigger outputs and the patched SoC signal, in the same clock domain as the SMUs.

---
 rtl/scu_pkg.sv | 9 +
 rtl/scu_hold_counter.sv | 18 +
 rtl/scu_unit.sv | 66 ++++++
 3 files changed

// File: rtl/scu_pkg.sv
// scu_pkg: shared types and constants for the signal control unit.
package scu_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, STICKY} scu_state_t;
  localparam logic [1:0] SCU_MODE_OFF     = 2'b00;
  localparam logic [1:0] SCU_MODE_ONESHOT = 2'b01;
  localparam logic [1:0] SCU_MODE_STICKY  = 2'b10;
  localparam logic [1:0] SCU_MODE_RETRIG  = 2'b11;
  localparam int SCU_PC_W = 8;
endpackage

// File: rtl/scu_hold_counter.sv
// scu_hold_counter: loadable down-counter that flags its final hold cycle.
module scu_hold_counter #(
  parameter int HW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [HW-1:0] load_val,
  input  logic          dec,
  output logic          expire
);
  logic [HW-1:0] count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (load) count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  assign expire = count == HW'(1);
endmodule

// File: rtl/scu_unit.sv
// scu_unit: applies a masked override to a signal bus on SMU triggers,
// held for a programmed time, sticky until cleared, or retriggerable.
module scu_unit
  import scu_pkg::*;
#(
  parameter int K  = 4,
  parameter int T  = 2,
  parameter int HW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [T-1:0]        trigger,
  input  logic [T-1:0]        RegTrigSel,
  input  logic [K-1:0]        RegCtlMask,
  input  logic [K-1:0]        RegCtlVal,
  input  logic [1:0]          RegCtlMode,
  input  logic [HW-1:0]       RegHold,
  input  logic                clear,
  input  logic [K-1:0]        s_in,
  output logic [K-1:0]        s_out,
  output logic                active,
  output logic [SCU_PC_W-1:0] PatchCount
);
  scu_state_t state, next;
  logic trig, load, bump, expire;
  logic [HW-1:0] hold_val;
  assign trig = |(trigger & RegTrigSel);
  assign hold_val = RegHold == '0 ? HW'(1) : RegHold;
  always_comb begin
    next = state;
    load = 1'b0;
    bump = 1'b0;
    if (clear || RegCtlMode == SCU_MODE_OFF) next = IDLE;
    else case (state)
      IDLE: if (trig) begin
        next = RegCtlMode == SCU_MODE_STICKY ? STICKY : HOLD;
        load = RegCtlMode != SCU_MODE_STICKY;
        bump = 1'b1;
      end
      // reload wins over expiry so a last-cycle retrigger leaves no gap
      HOLD: if (trig && RegCtlMode == SCU_MODE_RETRIG) begin
        load = 1'b1;
        bump = 1'b1;
      end else if (expire) next = IDLE;
      default: ;
    endcase
  end
  scu_hold_counter #(.HW(HW)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (hold_val),
    .dec      (state == HOLD && !load),
    .expire   (expire)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      PatchCount <= '0;
    end else begin
      state <= next;
      if (bump && PatchCount != '1) PatchCount <= PatchCount + 1'b1;
    end
  assign active = state != IDLE;
  assign s_out = active ? (s_in & ~RegCtlMask) | (RegCtlVal & RegCtlMask) : s_in;
endmodule
